// File: rtl/sevenseg_pkg.sv
// Shared types and the hex-to-segment lookup for the 4-digit seven-segment scanner.
// Segment patterns are active-low, bit 0 = segment a ... bit 6 = segment g.
package sevenseg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry n occupies bits [7*n +: 7]; digit 0 is the least significant slice.
  localparam logic [16*7-1:0] HEX7_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    return HEX7_LUT[7*nib +: 7];
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment cathode pattern.
module hex_to_7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex7(nib);
  end

endmodule

// File: rtl/sevenseg_scan_4digit.sv
// Time-multiplexed driver for a 4-digit common-anode display: slot counter, digit rotator,
// per-slot blank phase against ghosting, and registered active-low pin outputs.
module sevenseg_scan_4digit
  import sevenseg_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100_000,
  parameter int BLANK_TICKS     = 2_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output scan_state_e dbg_state
);

  localparam int CW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(TICKS_PER_DIGIT - 1);
  localparam bit            HAS_BLANK  = (BLANK_TICKS > 0);
  localparam logic [CW-1:0] BLANK_LAST = HAS_BLANK ? CW'(BLANK_TICKS - 1) : '0;

  logic [CW-1:0] count_q, count_d;
  logic [1:0]    idx_q, idx_d;
  scan_state_e   state_q, state_d;
  logic [3:0]    nib_q, nib_d;
  logic          en_q, en_d;
  logic          dpr_q, dpr_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          wrap;
  logic          snap;
  logic [6:0]    nib_seg;

  // On the snapshot cycle the live inputs are what is being latched, so they feed the
  // output path directly; this keeps a zero-blank build from showing the old nibble.
  hex_to_7seg u_hex (
    .nib (nib_d),
    .seg (nib_seg)
  );

  always_comb begin
    wrap    = (count_q == CNT_LAST);
    snap    = (count_q == '0);
    count_d = wrap ? '0 : count_q + 1'b1;
    idx_d   = wrap ? idx_q + 2'd1 : idx_q;

    nib_d = nib_q;
    en_d  = en_q;
    dpr_d = dpr_q;
    if (snap) begin
      nib_d = value[{idx_q, 2'b00} +: 4];
      en_d  = digit_en[idx_q];
      dpr_d = dp_in[idx_q];
    end

    state_d = state_q;
    case (state_q)
      BLANK: if (!HAS_BLANK || count_q == BLANK_LAST) state_d = DRIVE;
      DRIVE: if (HAS_BLANK && wrap) state_d = BLANK;
      default: state_d = BLANK;
    endcase

    an_d  = 4'b1111;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_q == DRIVE && en_d) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = nib_seg;
      dp_d  = ~dpr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      idx_q   <= '0;
      state_q <= BLANK;
      nib_q   <= '0;
      en_q    <= 1'b0;
      dpr_q   <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      count_q <= count_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      nib_q   <= nib_d;
      en_q    <= en_d;
      dpr_q   <= dpr_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign dbg_state = state_q;

endmodule
